gesture_uart_rx: RTL
====================

# gesture_uart_rx

Serial front end of the robot-arm gesture path. Receives gesture codes sent by the host classifier over a UART line, validates each frame and code, and applies a consecutive-match confirmation filter. It drives the stable `gesture` byte consumed directly by `gesture_decoder`. Rejected or unconfirmed frames never disturb the held gesture, so the servos only move on a deliberate, repeated command.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate. `CLKS_PER_BIT = CLK_HZ / BAUD`, integer-truncated; 434 at the defaults.
- `MAX_CODE`, 8'd10, highest legal gesture code. Codes above this are rejected.
- `CONFIRM_COUNT`, 2, number of consecutive identical valid frames required to commit a code. Legal range 1–15.

- `clk`, input, 1, system clock; all logic on the rising edge.
- `reset`, input, 1, asynchronous, active-high reset.
- `rx`, input, 1, asynchronous UART line; idles high.
- `gesture`, output, 8, last committed gesture code; held between commits.
- `gesture_valid`, output, 1, one-cycle pulse on each commit.
- `frame_err`, output, 1, one-cycle pulse for each frame rejected on framing, parity or code range.
- `busy`, output, 1, high while the FSM is outside IDLE.

## Operation
- **Input synchronizer:** `rx` passes through 2 flops before any use. Both flops reset to 1.
- **FSM states and transitions:**
  - IDLE: a synchronized falling edge moves to START and clears the bit counter.
  - START: wait `CLKS_PER_BIT/2` cycles, then resample. Low moves to DATA. High is a false start: return to IDLE with no error.
  - DATA: 8 samples, each `CLKS_PER_BIT` apart, shifted LSB first.
  - PARITY: present only with the macro; see Configuration.
  - STOP: sample one bit period after the last data/parity sample, then return to IDLE on the same edge. This allows a back-to-back start bit to be caught.
- **Frame accepted when:** stop sample = 1, parity is correct (if enabled), and byte ≤ `MAX_CODE`. Otherwise pulse `frame_err` exactly once per frame.
- **Confirmation filter:** holds a `cand` register and a 4-bit `cnt`.
  - Accepted byte == `cand`: `cnt` increments, saturating at `CONFIRM_COUNT`.
  - Accepted byte != `cand`: load `cand` with the byte and set `cnt` = 1.
  - Rejected frame: clear `cnt` to 0; `cand` is kept.
  - Commit occurs when `cnt` transitions to `CONFIRM_COUNT`: `gesture` ← `cand` and pulse `gesture_valid`. Further identical frames after a commit do not pulse again.
- **Code 0x00** is a legal code. It is filtered and committed like any other; the downstream decoder treats it as "hold".
- **Reset values:** `gesture` = 0, `gesture_valid` = 0, `frame_err` = 0, `busy` = 0, FSM in IDLE, `cand` = 0, `cnt` = 0, shift register = 0.
- **Reset mid-frame:** the partial frame is discarded. A receiver released during a low `rx` waits for high before arming; a falling edge is required.

## Timing
- Sample points are referenced to the synchronized falling edge: start at +`CLKS_PER_BIT/2`, bit n at +`CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`.
- The stop decision registers on the stop-sample edge. `gesture`, `gesture_valid` and `frame_err` are visible in the following cycle.
- Latency from the raw `rx` stop-bit midpoint to the outputs is 3 cycles: 2 synchronizer + 1 register.
- `gesture_valid` and `frame_err` are mutually exclusive and never asserted for more than 1 cycle.
- `busy` rises the cycle after edge detection and falls the cycle after the stop sample.

## Configuration
- Macro `GESTURE_PARITY_EN`.
- **Defined:** 8E1 framing. A PARITY state samples one bit after D7. Even parity is required across D0–D7 plus the parity bit; a mismatch is rejected via `frame_err`, reported at stop time (single pulse).
- **Undefined:** 8N1 framing. The PARITY state and its logic are absent, and STOP follows D7 directly.

## Test plan
- Two frames 0x03, `CONFIRM_COUNT` = 2 → after frame 1 `gesture` stays 0x00; after frame 2, `gesture` = 0x03 with one `gesture_valid` pulse. A third 0x03 produces no pulse.
- Frames 0x01, 0x02, 0x02 → single commit to 0x02; 0x01 is never committed.
- Frame 0x0B (> `MAX_CODE`) between two 0x05 frames → `frame_err` pulses once, `cnt` resets, no commit until two further 0x05 frames.
- Stop bit driven 0 on frame 0x04 → `frame_err` pulse, `gesture` unchanged. A 60-cycle low glitch on idle `rx` → false start, no error, `busy` drops.
- `reset` asserted at data bit 4 of a 0x07 frame → all outputs 0 immediately, next two clean 0x07 frames commit 0x07.
- With `GESTURE_PARITY_EN`: 0x03 sent with parity 1 → `frame_err`; with parity 0 ×2 → commit 0x03.

Source files
------------

// File: rtl/gesture_uart_rx.sv
// gesture_uart_rx
//   UART receiver for host gesture codes with frame/code validation and a
//   consecutive-match confirmation filter driving a held gesture byte.
//
//   Optional feature macro: GESTURE_PARITY_EN
//     defined   -> 8E1 framing (even parity bit after D7)
//     undefined -> 8N1 framing
//
//   Parameters:
//     CLK_HZ        system clock frequency in Hz
//     BAUD          line rate; CLKS_PER_BIT = CLK_HZ / BAUD
//     MAX_CODE      highest legal gesture code
//     CONFIRM_COUNT consecutive identical valid frames needed to commit (1..15)
//
//   Ports:
//     clk           system clock, rising edge
//     reset         asynchronous active-high reset
//     rx            asynchronous serial line, idles high
//     gesture       last committed gesture code, held between commits
//     gesture_valid one-cycle pulse on each commit
//     frame_err     one-cycle pulse per rejected frame (framing/parity/range)
//     busy          high while the receiver is outside IDLE
module gesture_uart_rx #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned BAUD          = 115200,
    parameter logic [7:0]  MAX_CODE      = 8'd10,
    parameter int unsigned CONFIRM_COUNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] gesture,
    output logic       gesture_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned TW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] FULL_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_BIT - 1);
    localparam logic [3:0]    CONFIRM    = 4'(CONFIRM_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef GESTURE_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic          rx_meta_q, rx_sync_q;
    logic [1:0]    fill_q;
    logic          line_hi_q, line_hi_d;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    gesture_q, gesture_d;
    logic          gv_q, gv_d;
    logic          fe_q, fe_d;
    logic          busy_q, busy_d;
    logic          frame_ok;
`ifdef GESTURE_PARITY_EN
    logic          par_q, par_d;
`endif

    // Both sync flops reset high, so their contents are meaningless until two
    // clocks after reset. fill_q marks when rx_sync_q reflects the real line;
    // line_hi_q only arms on a genuinely observed high, so a receiver released
    // while rx is low cannot mistake the reset value for an idle line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            fill_q    <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            fill_q    <= {fill_q[0], 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        gesture_d = gesture_q;
        gv_d      = 1'b0;
        fe_d      = 1'b0;
        line_hi_d = fill_q[1] & rx_sync_q;
`ifdef GESTURE_PARITY_EN
        par_d     = par_q;
        frame_ok  = rx_sync_q && (shift_q <= MAX_CODE) && !(^{shift_q, par_q});
`else
        frame_ok  = rx_sync_q && (shift_q <= MAX_CODE);
`endif

        case (state_q)
            S_IDLE: begin
                if (line_hi_q && !rx_sync_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (tick_q == HALF_LAST) begin
                    tick_d  = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_DATA: begin
                if (tick_q == FULL_LAST) begin
                    tick_d  = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef GESTURE_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
`ifdef GESTURE_PARITY_EN
            S_PARITY: begin
                if (tick_q == FULL_LAST) begin
                    tick_d  = '0;
                    par_d   = rx_sync_q;
                    state_d = S_STOP;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
`endif
            S_STOP: begin
                if (tick_q == FULL_LAST) begin
                    tick_d  = '0;
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        fe_d  = 1'b1;
                        cnt_d = '0;
                    end else if (shift_q == cand_q) begin
                        // Saturating count; commit only on the step that
                        // reaches CONFIRM so repeats after a commit stay quiet.
                        if (cnt_q < CONFIRM) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == CONFIRM) begin
                                gesture_d = shift_q;
                                gv_d      = 1'b1;
                            end
                        end
                    end else begin
                        cand_d = shift_q;
                        cnt_d  = 4'd1;
                        if (CONFIRM == 4'd1) begin
                            gesture_d = shift_q;
                            gv_d      = 1'b1;
                        end
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_hi_q <= 1'b0;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            gesture_q <= '0;
            gv_q      <= 1'b0;
            fe_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef GESTURE_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            line_hi_q <= line_hi_d;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            gesture_q <= gesture_d;
            gv_q      <= gv_d;
            fe_q      <= fe_d;
            busy_q    <= busy_d;
`ifdef GESTURE_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign gesture       = gesture_q;
    assign gesture_valid = gv_q;
    assign frame_err     = fe_q;
    assign busy          = busy_q;

endmodule
